// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: forward-select codes, scoreboard
// state enum and the default register-index width.
package hazard_pkg;

  localparam int REG_W_DEF = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwdSelT;

  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_BUSY = 1'b1
  } sbStateT;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side signal bundle for hazard_scoreboard.
// Optional perf-counter outputs appear when HAZARD_PERF_EN is defined.
interface hazard_scoreboard_if #(
  parameter int REG_W = 5,
  parameter int LAT_W = 4
);
  logic [REG_W-1:0] rs_d, rt_d;
  logic             branch_d, mc_op_d;
  logic [REG_W-1:0] rs_e, rt_e;
  logic [REG_W-1:0] wreg_e, wreg_m, wreg_w;
  logic             regwrite_e, regwrite_m, regwrite_w;
  logic             memtoreg_e, memtoreg_m;
  logic             mc_issue_e;
  logic [LAT_W-1:0] mc_lat_e;
  logic [REG_W-1:0] mc_dst_e;

  logic [1:0]       fwd_a_e, fwd_b_e;
  logic             fwd_a_d, fwd_b_d;
  logic             stall_f, stall_d, flush_e;
  logic             mc_busy, mc_wb;
  logic [REG_W-1:0] mc_wb_reg;
`ifdef HAZARD_PERF_EN
  logic [31:0]      stall_cycles, mc_stall_cycles;
`endif

  modport master (
    output rs_d, rt_d, branch_d, mc_op_d, rs_e, rt_e,
           wreg_e, wreg_m, wreg_w, regwrite_e, regwrite_m, regwrite_w,
           memtoreg_e, memtoreg_m, mc_issue_e, mc_lat_e, mc_dst_e,
    input  fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, stall_f, stall_d, flush_e,
           mc_busy, mc_wb, mc_wb_reg
`ifdef HAZARD_PERF_EN
           , stall_cycles, mc_stall_cycles
`endif
  );

  modport slave (
    input  rs_d, rt_d, branch_d, mc_op_d, rs_e, rt_e,
           wreg_e, wreg_m, wreg_w, regwrite_e, regwrite_m, regwrite_w,
           memtoreg_e, memtoreg_m, mc_issue_e, mc_lat_e, mc_dst_e,
    output fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, stall_f, stall_d, flush_e,
           mc_busy, mc_wb, mc_wb_reg
`ifdef HAZARD_PERF_EN
           , stall_cycles, mc_stall_cycles
`endif
  );
endinterface

// File: rtl/mc_scoreboard.sv
// Scoreboard for the single variable-latency multi-cycle unit.
//
//   state   | meaning
//   SB_IDLE | no multi-cycle op outstanding, accepts an issue
//   SB_BUSY | op in flight; cnt counts down, writeback when cnt==1
module mc_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_W   = REG_W_DEF,
  parameter int MAX_LAT = 8,
  parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mcIssue,
  input  logic [LAT_W-1:0] mcLat,
  input  logic [REG_W-1:0] mcDstIn,
  output logic             mcBusy,
  output logic             mcWb,
  output logic [REG_W-1:0] mcDst
);

  sbStateT          state, stateNxt;
  logic [LAT_W-1:0] cnt, cntNxt, loadVal;
  logic [REG_W-1:0] dstNxt;

  // Latency 0 still needs one cycle; anything beyond MAX_LAT saturates.
  always_comb begin
    loadVal = mcLat;
    if (mcLat == '0)
      loadVal = LAT_W'(1);
    else if (mcLat > LAT_W'(MAX_LAT))
      loadVal = LAT_W'(MAX_LAT);
  end

  // State, down-counter and destination register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SB_IDLE;
      cnt   <= '0;
      mcDst <= '0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
      mcDst <= dstNxt;
    end
  end

  // Next-state and writeback strobe; an issue while busy is ignored.
  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    dstNxt   = mcDst;
    mcWb     = 1'b0;
    case (state)
      SB_IDLE: begin
        if (mcIssue) begin
          stateNxt = SB_BUSY;
          cntNxt   = loadVal;
          dstNxt   = mcDstIn;
        end
      end
      SB_BUSY: begin
        cntNxt = cnt - LAT_W'(1);
        if (cnt == LAT_W'(1)) begin
          mcWb     = 1'b1;
          stateNxt = SB_IDLE;
        end
      end
      default: stateNxt = SB_IDLE;
    endcase
  end

  assign mcBusy = (state == SB_BUSY);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit: EX and branch forwarding, load-use/branch/multi-cycle stalls.
// Define HAZARD_PERF_EN to add the stall_cycles / mc_stall_cycles counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_W   = REG_W_DEF,
  parameter int MAX_LAT = 8,
  parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_scoreboard_if.slave hz
);

  logic             mcBusy, mcWb;
  logic [REG_W-1:0] mcDst;
  logic             lwStall, brStall, sbStall, stStall, stall;

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic regHit(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  function automatic logic srcHit(input logic [REG_W-1:0] dst, input logic [REG_W-1:0] s0,
                                  input logic [REG_W-1:0] s1);
    return regHit(dst, s0) || regHit(dst, s1);
  endfunction

  mc_scoreboard #(
    .REG_W  (REG_W),
    .MAX_LAT(MAX_LAT),
    .LAT_W  (LAT_W)
  ) uScoreboard (
    .clk    (clk),
    .rst_n  (rst_n),
    .mcIssue(hz.mc_issue_e),
    .mcLat  (hz.mc_lat_e),
    .mcDstIn(hz.mc_dst_e),
    .mcBusy (mcBusy),
    .mcWb   (mcWb),
    .mcDst  (mcDst)
  );

  // E-stage operand forwarding, M result has priority over W.
  always_comb begin
    hz.fwd_a_e = FWD_RF;
    hz.fwd_b_e = FWD_RF;
    if (hz.regwrite_m && regHit(hz.wreg_m, hz.rs_e))      hz.fwd_a_e = FWD_M;
    else if (hz.regwrite_w && regHit(hz.wreg_w, hz.rs_e)) hz.fwd_a_e = FWD_W;
    if (hz.regwrite_m && regHit(hz.wreg_m, hz.rt_e))      hz.fwd_b_e = FWD_M;
    else if (hz.regwrite_w && regHit(hz.wreg_w, hz.rt_e)) hz.fwd_b_e = FWD_W;
  end

  // Branch-compare forwarding and the four stall sources.
  always_comb begin
    hz.fwd_a_d = hz.branch_d && hz.regwrite_m && regHit(hz.wreg_m, hz.rs_d);
    hz.fwd_b_d = hz.branch_d && hz.regwrite_m && regHit(hz.wreg_m, hz.rt_d);
    lwStall = hz.memtoreg_e && hz.regwrite_e && srcHit(hz.wreg_e, hz.rs_d, hz.rt_d);
    brStall = hz.branch_d &&
              ((hz.regwrite_e && srcHit(hz.wreg_e, hz.rs_d, hz.rt_d)) ||
               (hz.memtoreg_m && srcHit(hz.wreg_m, hz.rs_d, hz.rt_d)));
    sbStall = (mcBusy && srcHit(mcDst, hz.rs_d, hz.rt_d)) ||
              (hz.mc_issue_e && srcHit(hz.mc_dst_e, hz.rs_d, hz.rt_d));
    stStall = hz.mc_op_d && (mcBusy || hz.mc_issue_e);
    stall   = lwStall || brStall || sbStall || stStall;
  end

  assign hz.stall_f   = stall;
  assign hz.stall_d   = stall;
  assign hz.flush_e   = stall;
  assign hz.mc_busy   = mcBusy;
  assign hz.mc_wb     = mcWb;
  assign hz.mc_wb_reg = mcDst;

`ifdef HAZARD_PERF_EN
  logic [31:0] stallCnt, mcStallCnt;

  // Saturating counters of total and multi-cycle-induced stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt   <= '0;
      mcStallCnt <= '0;
    end else begin
      if (stall && (stallCnt != '1))
        stallCnt <= stallCnt + 32'd1;
      if ((sbStall || stStall) && (mcStallCnt != '1))
        mcStallCnt <= mcStallCnt + 32'd1;
    end
  end

  assign hz.stall_cycles    = stallCnt;
  assign hz.mc_stall_cycles = mcStallCnt;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized scoreboard bench for hazard_scoreboard with a cycle-indexed
// reference model (pending op remembered by its absolute writeback cycle).
module tb_hazard_scoreboard;

  localparam int REG_W   = 5;
  localparam int MAX_LAT = 8;
  localparam int LAT_W   = 4;

  typedef struct {
    logic [4:0] rsD, rtD, rsE, rtE, wregE, wregM, wregW, mcDstE;
    logic       branchD, mcOpD, rwE, rwM, rwW, mtrE, mtrM, mcIssue, rstN;
    logic [3:0] mcLat;
  } vecT;

  typedef struct {
    int          cyc;
    logic [16:0] outs;
    logic [31:0] sc, msc;
  } expT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_W(REG_W), .LAT_W(LAT_W)) hz ();

  hazard_scoreboard #(.REG_W(REG_W), .MAX_LAT(MAX_LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz)
  );

  expT expQ[$];
  int  vectors = 0;
  int  miscompares = 0;

  // reference model state
  int         cyc = 0;
  bit         pendActive = 0;
  int         pendWb = 0;
  logic [4:0] lastDst = '0;
  longint     stallCnt = 0, mcStallCnt = 0;

  function automatic bit inD(input logic [4:0] r, input vecT v);
    return (r != 0) && (r == v.rsD || r == v.rtD);
  endfunction

  function automatic logic [1:0] fwdE(input logic [4:0] src, input vecT v);
    if (src != 0 && v.rwM && v.wregM == src) return 2'b10;
    if (src != 0 && v.rwW && v.wregW == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic vecT idle();
    vecT v;
    v = '{default: '0};
    v.rstN = 1'b1;
    return v;
  endfunction

  task automatic step(input vecT v);
    expT e;
    bit  busy, wb, lw, br, sb, st, stl, fad, fbd;
    int  eff;
    @(negedge clk);
    rst_n         = v.rstN;
    hz.rs_d       = v.rsD;   hz.rt_d       = v.rtD;
    hz.branch_d   = v.branchD; hz.mc_op_d  = v.mcOpD;
    hz.rs_e       = v.rsE;   hz.rt_e       = v.rtE;
    hz.wreg_e     = v.wregE; hz.wreg_m     = v.wregM; hz.wreg_w = v.wregW;
    hz.regwrite_e = v.rwE;   hz.regwrite_m = v.rwM;   hz.regwrite_w = v.rwW;
    hz.memtoreg_e = v.mtrE;  hz.memtoreg_m = v.mtrM;
    hz.mc_issue_e = v.mcIssue; hz.mc_lat_e = v.mcLat; hz.mc_dst_e = v.mcDstE;
    #1;
    if (!v.rstN) begin
      pendActive = 0; lastDst = '0; stallCnt = 0; mcStallCnt = 0;
    end
    busy = pendActive;
    wb   = pendActive && (cyc == pendWb);
    lw   = v.mtrE && v.rwE && inD(v.wregE, v);
    br   = v.branchD && ((v.rwE && inD(v.wregE, v)) || (v.mtrM && inD(v.wregM, v)));
    sb   = (busy && inD(lastDst, v)) || (v.mcIssue && inD(v.mcDstE, v));
    st   = v.mcOpD && (busy || v.mcIssue);
    stl  = lw || br || sb || st;
    fad  = v.branchD && v.rwM && v.wregM != 0 && v.wregM == v.rsD;
    fbd  = v.branchD && v.rwM && v.wregM != 0 && v.wregM == v.rtD;
    e.cyc  = cyc;
    e.outs = {fwdE(v.rsE, v), fwdE(v.rtE, v), fad, fbd, stl, stl, stl, busy, wb, lastDst};
    e.sc   = 32'(stallCnt);
    e.msc  = 32'(mcStallCnt);
    expQ.push_back(e);
    if (v.rstN) begin
      if (stl && stallCnt < 64'hFFFF_FFFF) stallCnt++;
      if ((sb || st) && mcStallCnt < 64'hFFFF_FFFF) mcStallCnt++;
      if (wb) pendActive = 0;
      if (v.mcIssue && !busy) begin
        eff = (v.mcLat == 0) ? 1 : ((v.mcLat > MAX_LAT) ? MAX_LAT : int'(v.mcLat));
        pendActive = 1;
        pendWb     = cyc + eff;
        lastDst    = v.mcDstE;
      end
    end
    cyc++;
  endtask

  task automatic issueOp(input logic [3:0] lat, input logic [4:0] dst);
    vecT v;
    v = idle(); v.mcIssue = 1; v.mcLat = lat; v.mcDstE = dst;
    step(v);
  endtask

  task automatic readD(input logic [4:0] r, input bit mcOp, input int n);
    vecT v;
    v = idle(); v.rsD = r; v.mcOpD = mcOp;
    for (int i = 0; i < n; i++) step(v);
  endtask

  // monitor: outputs are presented every cycle, compare against the queue
  initial begin
    expT  e;
    logic [16:0] act;
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        e   = expQ.pop_front();
        act = {hz.fwd_a_e, hz.fwd_b_e, hz.fwd_a_d, hz.fwd_b_d, hz.stall_f, hz.stall_d,
               hz.flush_e, hz.mc_busy, hz.mc_wb, hz.mc_wb_reg};
        vectors++;
        if (act !== e.outs) begin
          miscompares++;
          $display("FAIL outputs cyc=%0d got=%b exp=%b (fa fb fad fbd sf sd fe busy wb wbreg)",
                   e.cyc, act, e.outs);
        end
`ifdef HAZARD_PERF_EN
        vectors++;
        if (hz.stall_cycles !== e.sc || hz.mc_stall_cycles !== e.msc) begin
          miscompares++;
          $display("FAIL perf cyc=%0d got=%0d/%0d exp=%0d/%0d", e.cyc,
                   hz.stall_cycles, hz.mc_stall_cycles, e.sc, e.msc);
        end
`endif
      end
    end
  end

  initial begin
    vecT v;
    v = idle(); v.rstN = 0;
    step(v); step(v);
    // forwarding priority and register 0
    v = idle(); v.wregM = 5; v.rwM = 1; v.wregW = 5; v.rwW = 1; v.rsE = 5; v.rtE = 5;
    step(v);
    v.rwM = 0; step(v);
    v = idle(); v.rwM = 1; v.rwW = 1; step(v);
    // load-use then clear
    v = idle(); v.wregE = 8; v.rwE = 1; v.mtrE = 1; v.rtD = 8; step(v);
    step(idle());
    // branch on ALU result in E, then forwarded from M
    v = idle(); v.branchD = 1; v.rsD = 9; v.wregE = 9; v.rwE = 1; step(v);
    v = idle(); v.branchD = 1; v.rsD = 9; v.wregM = 9; v.rwM = 1; step(v);
    // mult latency 4, dependent waits through writeback
    issueOp(4'd4, 5'd10); readD(5'd10, 0, 5);
    // structural stall, latency 0, saturated latency
    issueOp(4'd2, 5'd3); readD(5'd0, 1, 3);
    issueOp(4'd0, 5'd4); readD(5'd4, 0, 2);
    issueOp(4'd15, 5'd6); readD(5'd6, 0, 10);
    // reset while busy at cnt=3
    issueOp(4'd5, 5'd7); readD(5'd7, 0, 2);
    v = idle(); v.rsD = 7; v.rstN = 0; step(v);
    readD(5'd7, 0, 6);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      v = idle();
      v.rsD = 5'($urandom_range(0, 3)); v.rtD = 5'($urandom_range(0, 3));
      v.rsE = 5'($urandom_range(0, 3)); v.rtE = 5'($urandom_range(0, 3));
      v.wregE = 5'($urandom_range(0, 3)); v.wregM = 5'($urandom_range(0, 3));
      v.wregW = 5'($urandom_range(0, 3)); v.mcDstE = 5'($urandom_range(0, 3));
      v.branchD = ($urandom_range(0, 2) == 0); v.mcOpD = ($urandom_range(0, 3) == 0);
      v.rwE = 1'($urandom); v.rwM = 1'($urandom); v.rwW = 1'($urandom);
      v.mtrE = 1'($urandom); v.mtrM = 1'($urandom);
      v.mcIssue = ($urandom_range(0, 4) == 0); v.mcLat = 4'($urandom_range(0, 15));
      v.rstN = ($urandom_range(0, 199) != 0);
      step(v);
    end
    repeat (3) @(negedge clk);
    if (expQ.size() != 0) begin
      miscompares++;
      $display("FAIL drain got=%0d pending exp=0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
